// File: rtl/timer_apb_pkg.sv
// Shared types and constants for the timer APB arbiter slice.
// Contents:
//   apb_state_e      - arbiter FSM state encoding
//   TDR/TCR/TSR      - timer register addresses
//   TSR_OVF/TSR_UDF  - status register bit positions
package timer_apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } apb_state_e;

    localparam logic [7:0] TDR = 8'h00;
    localparam logic [7:0] TCR = 8'h01;
    localparam logic [7:0] TSR = 8'h02;

    localparam int unsigned TSR_OVF = 0;
    localparam int unsigned TSR_UDF = 1;

endpackage

// File: rtl/timer_apb_arbiter_if.sv
// Bundle of requester-side and APB-side signals of the timer APB arbiter.
// Modports:
//   master - the arbiter: takes requests, drives APB control and completions
//   slave  - the environment: requesters plus the APB register block
// Signals:
//   req0/1, wr0/1, addr0/1, wdata0/1  - requester commands
//   done0/1, rdata, err, busy         - completion and status back to requesters
//   psel, penable, pwrite, paddr, pwdata, prdata, pready, pslverr - APB
interface timer_apb_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic              req0;
    logic              req1;
    logic              wr0;
    logic              wr1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              done0;
    logic              done1;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              busy;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
        output done0, done1, rdata, err, busy,
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
        input  done0, done1, rdata, err, busy,
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/timer_apb_arbiter_rr_arb2.sv
// Two-input round-robin arbiter with a registered last-grant pointer.
// Ports:
//   clk, rst_n    - clock, async active-low reset (pointer resets to 1)
//   req0_i/req1_i - requests
//   advance_i     - commit the current grant into the pointer
//   gnt_vld_c_o   - combinational: some request present
//   gnt_idx_c_o   - combinational: index of the winner
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req0_i,
    input  logic req1_i,
    input  logic advance_i,
    output logic gnt_vld_c_o,
    output logic gnt_idx_c_o
);

    logic last_q;
    logic last_d;

    // Grant: a lone requester wins; on conflict the one not granted last wins.
    always_comb begin
        gnt_vld_c_o = req0_i | req1_i;
        if (req0_i && req1_i) begin
            gnt_idx_c_o = ~last_q;
        end else begin
            gnt_idx_c_o = req1_i;
        end
        last_d = last_q;
        if (advance_i && gnt_vld_c_o) begin
            last_d = gnt_idx_c_o;
        end
    end

    // Pointer starts at 1 so requester 0 wins the first conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/timer_apb_arbiter.sv
// Two-requester APB master front-end for the timer register block.
// Round-robin arbitration in IDLE, then a SETUP/ACCESS APB transfer; the
// result is returned to the winner on a one-cycle done pulse. All outputs
// are registered.
// Ports:
//   pclk    - clock
//   presetn - async active-low reset; abandons any transfer without done
//   bus     - timer_apb_arbiter_if.master (requester and APB signals)
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase that sees
// no pready within TIMEOUT_CYC cycles (completes with err = 1, rdata = 0).
module timer_apb_arbiter
    import timer_apb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic                pclk,
    input  logic                presetn,
    timer_apb_arbiter_if.master bus
);

    if (TIMEOUT_CYC == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    apb_state_e        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic              busy_q, busy_d;

    logic              arb_vld_c;
    logic              arb_idx_c;
    logic              arb_adv_c;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]  tcnt_q, tcnt_d;
`endif

    rr_arb2 u_arb (
        .clk         (pclk),
        .rst_n       (presetn),
        .req0_i      (bus.req0),
        .req1_i      (bus.req1),
        .advance_i   (arb_adv_c),
        .gnt_vld_c_o (arb_vld_c),
        .gnt_idx_c_o (arb_idx_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        arb_adv_c = 1'b0;
`ifdef APB_TIMEOUT_EN
        tcnt_d    = tcnt_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (arb_vld_c) begin
                    arb_adv_c = 1'b1;
                    gnt_d     = arb_idx_c;
                    pwrite_d  = arb_idx_c ? bus.wr1    : bus.wr0;
                    paddr_d   = arb_idx_c ? bus.addr1  : bus.addr0;
                    pwdata_d  = arb_idx_c ? bus.wdata1 : bus.wdata0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = ST_SETUP;
                end
            end

            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
`ifdef APB_TIMEOUT_EN
                tcnt_d    = '0;
`endif
            end

            ST_ACCESS: begin
                if (bus.pready) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    rdata_d   = pwrite_q ? '0 : bus.prdata;
                    err_d     = bus.pslverr;
                    done0_d   = ~gnt_q;
                    done1_d   = gnt_q;
                    state_d   = ST_DONE;
                end
`ifdef APB_TIMEOUT_EN
                // Expiry only when pready is absent on the final allowed cycle.
                else if (tcnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    rdata_d   = '0;
                    err_d     = 1'b1;
                    done0_d   = ~gnt_q;
                    done1_d   = gnt_q;
                    state_d   = ST_DONE;
                end else begin
                    tcnt_d    = tcnt_q + CNT_W'(1);
                end
`endif
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            busy_q    <= busy_d;
        end
    end

`ifdef APB_TIMEOUT_EN
    // ACCESS cycle counter.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end
`endif

    assign bus.psel    = psel_q;
    assign bus.penable = penable_q;
    assign bus.pwrite  = pwrite_q;
    assign bus.paddr   = paddr_q;
    assign bus.pwdata  = pwdata_q;
    assign bus.rdata   = rdata_q;
    assign bus.err     = err_q;
    assign bus.done0   = done0_q;
    assign bus.done1   = done1_q;
    assign bus.busy    = busy_q;

endmodule
